// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core.
// It detects load-use hazards between IF/ID and ID/EX, sequences the jr
// redirect penalty, and freezes the pipe while data memory is busy.
// It also keeps a saturating count of non-advancing cycles.
// All control outputs are combinational from the current state and inputs,
// so a load-use bubble takes effect in the cycle the hazard is seen.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned JR_PENALTY     = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [4:0]       IFID_OPCODE,
    input  logic [2:0]       IFID_R1_ADDR,
    input  logic [2:0]       IFID_R2_ADDR,
    input  logic [4:0]       IDEX_OPCODE,
    input  logic [2:0]       IDEX_RD_ADDR,
    input  logic             IDEX_VALID,
    input  logic             DMEM_REQ,
    input  logic             DMEM_ACK,
    output logic             PC_WE,
    output logic             IFID_WE,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             FREEZE,
    output logic             JR_TAKE,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [4:0] OP_LOAD     = 5'b11010;
    localparam logic [4:0] OP_JR       = 5'b11000;
    localparam logic [2:0] LD_CNT_INIT = 3'(LOAD_STALL_CYC - 1);
    localparam logic [2:0] JR_CNT_INIT = 3'(JR_PENALTY);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_JR_WAIT  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    state_t           state_r, state_nxt_s;
    state_t           ret_r, ret_nxt_s;
    logic [2:0]       cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic lu_s, mw_s;
    logic pc_we_s, ifid_we_s, flush_s, bubble_s, freeze_s, take_s, stall_s;

    // Hazard conditions: load-use on a nonzero register, and memory wait.
    always_comb begin
        lu_s = IDEX_VALID && (IDEX_OPCODE == OP_LOAD) && (IDEX_RD_ADDR != 3'b000) &&
               ((IDEX_RD_ADDR == IFID_R1_ADDR) || (IDEX_RD_ADDR == IFID_R2_ADDR));
        mw_s = DMEM_REQ & ~DMEM_ACK;
    end

    // Next-state and control outputs; memory wait always wins, then the state's own action.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        cnt_nxt_s   = cnt_r;
        pc_we_s     = 1'b1;
        ifid_we_s   = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        freeze_s    = 1'b0;
        take_s      = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mw_s) begin
                    freeze_s    = 1'b1;
                    pc_we_s     = 1'b0;
                    ifid_we_s   = 1'b0;
                    stall_s     = 1'b1;
                    ret_nxt_s   = ST_RUN;
                    state_nxt_s = ST_MEM_WAIT;
                end else if (lu_s) begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    bubble_s  = 1'b1;
                    stall_s   = 1'b1;
                    cnt_nxt_s = LD_CNT_INIT;
                    if (LD_CNT_INIT != 3'd0) begin
                        state_nxt_s = ST_LD_STALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (IFID_OPCODE == OP_JR) begin
                    cnt_nxt_s   = JR_CNT_INIT;
                    state_nxt_s = ST_JR_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LD_STALL: begin
                if (mw_s) begin
                    freeze_s    = 1'b1;
                    pc_we_s     = 1'b0;
                    ifid_we_s   = 1'b0;
                    stall_s     = 1'b1;
                    ret_nxt_s   = ST_LD_STALL;
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    bubble_s  = 1'b1;
                    stall_s   = 1'b1;
                    // cnt == 1 marks the last bubble; <= also recovers a stray zero.
                    if (cnt_r <= 3'd1) begin
                        cnt_nxt_s   = 3'd0;
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end
            end
            ST_JR_WAIT: begin
                if (mw_s) begin
                    freeze_s    = 1'b1;
                    pc_we_s     = 1'b0;
                    ifid_we_s   = 1'b0;
                    stall_s     = 1'b1;
                    ret_nxt_s   = ST_JR_WAIT;
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    pc_we_s = 1'b0;
                    flush_s = 1'b1;
                    stall_s = 1'b1;
                    if (cnt_r <= 3'd1) begin
                        take_s      = 1'b1;
                        pc_we_s     = 1'b1;
                        cnt_nxt_s   = 3'd0;
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                freeze_s  = 1'b1;
                pc_we_s   = 1'b0;
                ifid_we_s = 1'b0;
                stall_s   = 1'b1;
                if (!mw_s) begin
                    state_nxt_s = ret_r;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                ret_nxt_s   = ST_RUN;
                cnt_nxt_s   = 3'd0;
            end
        endcase
        // A frozen pipe must not flush, bubble or redirect.
        if (freeze_s) begin
            flush_s  = 1'b0;
            bubble_s = 1'b0;
            take_s   = 1'b0;
        end else begin
            flush_s  = flush_s;
            bubble_s = bubble_s;
            take_s   = take_s;
        end
    end

    // State, return state, sequence counter and saturating stall counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_RUN;
            ret_r       <= ST_RUN;
            cnt_r       <= 3'd0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ret_r   <= ret_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Drive outputs, all forced low while reset is asserted.
    always_comb begin
        if (nRST) begin
            PC_WE       = pc_we_s;
            IFID_WE     = ifid_we_s;
            IFID_FLUSH  = flush_s;
            IDEX_BUBBLE = bubble_s;
            FREEZE      = freeze_s;
            JR_TAKE     = take_s;
            STALL       = stall_s;
            STALL_CNT   = stall_cnt_r;
        end else begin
            PC_WE       = 1'b0;
            IFID_WE     = 1'b0;
            IFID_FLUSH  = 1'b0;
            IDEX_BUBBLE = 1'b0;
            FREEZE      = 1'b0;
            JR_TAKE     = 1'b0;
            STALL       = 1'b0;
            STALL_CNT   = '0;
        end
    end

endmodule
